// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the ducking audio mixer.
package audio_mix_pkg;

    typedef enum logic [1:0] {IDLE, ATTACK, HOLD, RELEASE} duck_state_t;

    localparam int W_DEF     = 16;
    localparam int N_SFX_DEF = 2;
    // Sum width for the default configuration: one guard bit per doubling of channel count.
    localparam int SUM_W     = W_DEF + $clog2(N_SFX_DEF + 1);

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/duck_envelope.sv
// Music attenuation envelope: ramps the duck level up while effects play,
// holds it at the maximum, then ramps it back down.
module duck_envelope
    import audio_mix_pkg::*;
#(
    parameter int DUCK_MAX     = 2,
    parameter int RAMP_SAMPLES = 64,
    parameter int HOLD_SAMPLES = 512,
    parameter int LVL_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic             any_act,
    input  logic             en_duck,
    output logic [LVL_W-1:0] level,
    output duck_state_t      state
);

    localparam int RCW = $clog2(RAMP_SAMPLES + 1);
    localparam int HCW = $clog2(HOLD_SAMPLES + 1);
    localparam logic [RCW-1:0]   RAMP_LAST = RCW'(RAMP_SAMPLES - 1);
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD_SAMPLES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(DUCK_MAX);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

    logic [RCW-1:0] ramp_cnt;
    logic [HCW-1:0] hold_cnt;

    // Everything advances only on sample_tick; counters clear on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            level    <= '0;
            ramp_cnt <= '0;
            hold_cnt <= '0;
        end else if (sample_tick) begin
            case (state)
                IDLE: begin
                    level <= '0;
                    if (any_act && en_duck && (DUCK_MAX > 0)) begin
                        state    <= ATTACK;
                        ramp_cnt <= '0;
                    end
                end
                ATTACK: begin
                    if (!en_duck) begin
                        state    <= RELEASE;
                        ramp_cnt <= '0;
                    end else if (level >= LVL_MAX) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else if (ramp_cnt == RAMP_LAST) begin
                        level    <= level + LVL_ONE;
                        ramp_cnt <= '0;
                        if (level + LVL_ONE == LVL_MAX) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end else begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!en_duck) begin
                        state    <= RELEASE;
                        ramp_cnt <= '0;
                        hold_cnt <= '0;
                    end else if (any_act) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= RELEASE;
                        ramp_cnt <= '0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (any_act && en_duck) begin
                        state    <= ATTACK;
                        ramp_cnt <= '0;
                    end else if (level == '0) begin
                        state    <= IDLE;
                        ramp_cnt <= '0;
                    end else if (ramp_cnt == RAMP_LAST) begin
                        level    <= level - LVL_ONE;
                        ramp_cnt <= '0;
                        if (level == LVL_ONE)
                            state <= IDLE;
                    end else begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    level    <= '0;
                    ramp_cnt <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/audio_mixer_duck.sv
// Music plus N_SFX effect channels mixed to one saturated mono sample,
// with the music ducked by a ramped envelope while effects play.
module audio_mixer_duck
    import audio_mix_pkg::*;
#(
    parameter int W            = 16,
    parameter int N_SFX        = 2,
    parameter int DUCK_MAX     = 2,
    parameter int RAMP_SAMPLES = 64,
    parameter int HOLD_SAMPLES = 512,
    localparam int LVL_W       = (DUCK_MAX > 0) ? $clog2(DUCK_MAX + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic signed [W-1:0]   music_in,
    input  logic [N_SFX*W-1:0]    sfx_in,
    input  logic [N_SFX-1:0]      sfx_active,
    input  logic                  en_duck,
    input  logic                  mute,
    output logic signed [W-1:0]   mix_out,
    output logic                  mix_valid,
    output logic [LVL_W-1:0]      duck_level,
    output logic                  clip,
    output duck_state_t           duck_state
);

    localparam int SUM_W_L = W + $clog2(N_SFX + 1);

    // Stream protocol: sample_tick is a one-cycle strobe with no backpressure;
    // every tick yields exactly one mix_valid pulse two cycles later.

    logic                s1_valid;
    logic                s1_mute;
    logic signed [W-1:0] s1_music;
    logic signed [W-1:0] s1_sfx [N_SFX];

    logic signed [SUM_W_L-1:0] sum;
    logic signed [31:0]        sat_full;
    logic                      ovf;

    duck_envelope #(
        .DUCK_MAX     (DUCK_MAX),
        .RAMP_SAMPLES (RAMP_SAMPLES),
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .LVL_W        (LVL_W)
    ) u_env (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .any_act     (|sfx_active),
        .en_duck     (en_duck),
        .level       (duck_level),
        .state       (duck_state)
    );

    // Music is shifted by the level in force during the tick cycle, before the envelope steps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mute  <= 1'b0;
            s1_music <= '0;
            for (int k = 0; k < N_SFX; k++)
                s1_sfx[k] <= '0;
        end else begin
            s1_valid <= sample_tick;
            if (sample_tick) begin
                s1_mute  <= mute;
                s1_music <= music_in >>> duck_level;
                for (int k = 0; k < N_SFX; k++)
                    s1_sfx[k] <= sfx_active[k] ? sfx_in[k*W +: W] : '0;
            end
        end
    end

    always_comb begin
        sum = SUM_W_L'(s1_music);
        for (int k = 0; k < N_SFX; k++)
            sum = sum + SUM_W_L'(s1_sfx[k]);
    end

    assign sat_full = saturate(32'(sum), W);
    assign ovf      = (sat_full != 32'(sum));

    always_ff @(posedge clk) begin
        if (!rst) begin
            mix_out   <= '0;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            mix_valid <= s1_valid;
            clip      <= s1_valid & ~s1_mute & ovf;
            if (s1_valid)
                mix_out <= s1_mute ? '0 : W'(sat_full);
        end
    end

endmodule
